context_row_buffer: RTL and testbench

Three-row line buffer that sits directly upstream of `context_encoder`. It accepts the bit-plane image as a row-major stream of 16-bit words and presents the encoder with a vertically aligned 3-row window (above / current / below), one column word per row. The column advances each time the encoder pulses `ram_update_flag`, and the block generates `cal_flag`. Image borders are supplied as zero words, so the encoder needs no edge handling.

---
 rtl/context_row_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_context_row_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/context_row_buffer.sv
// Three-row line buffer ahead of context_encoder: rows land in a 4-bank ring and
// a column sweep presents above/current/below words with zero borders.
module context_row_buffer #(
  parameter int WORDS_PER_ROW = 25,
  parameter int ROWS          = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      ram_update_flag,
  output logic [DATA_WIDTH-1:0]     data_output_row0,
  output logic [DATA_WIDTH-1:0]     data_output_row1,
  output logic [DATA_WIDTH-1:0]     data_output_row2,
  output logic                      cal_flag,
  output logic                      window_valid,
  output logic [$clog2(ROWS)-1:0]   row_index,
  output logic                      frame_done,
  output logic [1:0]                dbg_state
);

  localparam int W   = WORDS_PER_ROW;
  localparam int AW  = (W > 1) ? $clog2(W) : 1;
  localparam int CW  = $clog2(W + 2);
  localparam int RIW = $clog2(ROWS);
  localparam int RCW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    S_PRELOAD = 2'd0,
    S_SWEEP   = 2'd1,
    S_WAIT    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               state_q, state_n;
  logic [RIW-1:0]       row_q, row_n;
  logic [CW-1:0]        col_q, col_n;
  logic [1:0]           top_q, top_n;
  logic [1:0]           wr_ptr_q;
  logic [AW-1:0]        wr_addr_q;
  logic [RCW-1:0]       rows_wr_q, rows_avail;
  logic [3:0]           full_q;
  logic [1:0]           free_bank;
  logic                 accept, wr_last, rotate, clear;
  logic                 next_stored, next_beyond;
  logic [DATA_WIDTH-1:0] mem [4][W];

  // Handshake: a word moves on any rising edge where in_valid && in_ready; in_ready
  // depends only on registered state, so the producer may hold in_valid freely.
  assign in_ready   = !rst && !full_q[wr_ptr_q] && (rows_wr_q < RCW'(ROWS));
  assign accept     = in_valid && in_ready;
  assign wr_last    = accept && (wr_addr_q == AW'(W - 1));
  assign rows_avail = rows_wr_q + RCW'(wr_last);

  // A row finishing on this edge already counts as stored for the sweep decision.
  assign next_stored = int'(rows_avail) > int'(row_q) + 2;
  assign next_beyond = int'(row_q) + 2 >= ROWS;
  assign free_bank   = top_q - 2'd1;

  assign row_index = row_q;
  assign dbg_state = state_q;

  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    col_n   = col_q;
    top_n   = top_q;
    rotate  = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      S_PRELOAD: begin
        if (rows_avail >= RCW'(2)) begin
          state_n = S_SWEEP;
          row_n   = '0;
          col_n   = '0;
          top_n   = '0;
        end
      end
      S_SWEEP: begin
        if (ram_update_flag) begin
          if (col_q != CW'(W + 1))
            col_n = col_q + 1'b1;
          else if (row_q == RIW'(ROWS - 1))
            state_n = S_DONE;
          else if (next_stored || next_beyond)
            rotate = 1'b1;
          else
            state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (next_stored) begin
          rotate  = 1'b1;
          state_n = S_SWEEP;
        end
      end
      S_DONE: begin
        clear   = 1'b1;
        state_n = S_PRELOAD;
        row_n   = '0;
        col_n   = '0;
        top_n   = '0;
      end
      default: state_n = S_PRELOAD;
    endcase
    if (rotate) begin
      row_n = row_q + 1'b1;
      col_n = '0;
      top_n = top_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_PRELOAD;
      row_q   <= '0;
      col_q   <= '0;
      top_q   <= '0;
    end else begin
      state_q <= state_n;
      row_q   <= row_n;
      col_q   <= col_n;
      top_q   <= top_n;
    end
  end

  // Leaving row r releases the bank of row r-1; at r=0 no bank is above the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      wr_addr_q <= '0;
      rows_wr_q <= '0;
      full_q    <= '0;
    end else if (clear) begin
      wr_ptr_q  <= '0;
      wr_addr_q <= '0;
      rows_wr_q <= '0;
      full_q    <= '0;
    end else begin
      if (rotate && (row_q != '0))
        full_q[free_bank] <= 1'b0;
      if (wr_last) begin
        full_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
        wr_addr_q        <= '0;
        rows_wr_q        <= rows_wr_q + 1'b1;
      end else if (accept) begin
        wr_addr_q <= wr_addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr_q][wr_addr_q] <= in_data;
  end

  logic                  sweep_n, pad;
  logic [AW-1:0]         rd_addr;
  logic [1:0]            rb_above, rb_below;
  logic [DATA_WIDTH-1:0] row0_n, row1_n, row2_n;

  // Window words are looked up for the column about to be presented, then registered.
  always_comb begin
    sweep_n  = (state_n == S_SWEEP);
    pad      = (col_n == '0) || (col_n == CW'(W + 1));
    rd_addr  = pad ? '0 : AW'(col_n - 1'b1);
    rb_above = top_n - 2'd1;
    rb_below = top_n + 2'd1;
    row0_n   = '0;
    row1_n   = '0;
    row2_n   = '0;
    if (sweep_n && !pad) begin
      row1_n = mem[top_n][rd_addr];
      if (row_n != '0)
        row0_n = mem[rb_above][rd_addr];
      if (row_n != RIW'(ROWS - 1))
        row2_n = mem[rb_below][rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_output_row0 <= '0;
      data_output_row1 <= '0;
      data_output_row2 <= '0;
      window_valid     <= 1'b0;
      cal_flag         <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      data_output_row0 <= row0_n;
      data_output_row1 <= row1_n;
      data_output_row2 <= row2_n;
      window_valid     <= sweep_n;
      cal_flag         <= sweep_n && (col_n >= CW'(2));
      frame_done       <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_context_row_buffer.sv
// Bench for context_row_buffer with a 25-word, 4-row frame: window contents,
// stalls, same-edge rotation, frame completion and mid-frame reset.
module tb_context_row_buffer;

  localparam int W  = 25;
  localparam int R  = 4;
  localparam int DW = 16;
  localparam int EW = 3 * DW + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ram_update_flag;
  logic [DW-1:0] data_output_row0, data_output_row1, data_output_row2;
  logic          cal_flag, window_valid, frame_done;
  logic [1:0]    row_index;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  context_row_buffer #(.WORDS_PER_ROW(W), .ROWS(R), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_update_flag(ram_update_flag),
    .data_output_row0(data_output_row0),
    .data_output_row1(data_output_row1),
    .data_output_row2(data_output_row2),
    .cal_flag(cal_flag), .window_valid(window_valid),
    .row_index(row_index), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  typedef struct {
    int            c;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic          cal;
  } vec_t;

  vec_t          tbl[6];
  int            n_vec = 0;
  int            n_bad = 0;
  int            fd_cnt = 0;
  logic [EW-1:0] exp_q[$];

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  function automatic logic [DW-1:0] model_word(int row, int col);
    if (row < 0 || row >= R || col == 0 || col == W + 1) return '0;
    return DW'(row * 256 + col - 1);
  endfunction

  function automatic logic [EW-1:0] model_win(int r, int c);
    logic [1:0] ri;
    ri = 2'(r);
    return {model_word(r - 1, c), model_word(r, c), model_word(r + 1, c), 1'(c >= 2), 1'b1, ri};
  endfunction

  function automatic logic [EW-1:0] dut_win();
    return {data_output_row0, data_output_row1, data_output_row2, cal_flag, window_valid, row_index};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_sb(input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got no expected entry, want one queued", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, 64'(dut_win()), 64'(e));
    end
  endtask

  // Tasks start and end just after a falling edge.
  task automatic write_words(input int row, input int first, input int last, output int stalls);
    int waited;
    stalls = 0;
    for (int col = first; col <= last; col++) begin
      waited   = 0;
      in_valid = 1'b1;
      in_data  = DW'(row * 256 + col);
      while (!in_ready && waited < 200) begin
        @(negedge clk);
        waited++;
        stalls++;
      end
      if (!in_ready) begin
        n_vec++;
        n_bad++;
        $display("FAIL write_timeout row %0d col %0d: got in_ready 0, want 1", row, col);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse(input int r, input int c);
    exp_q.push_back(model_win(r, c));
    ram_update_flag = 1'b1;
    @(negedge clk);
    ram_update_flag = 1'b0;
    check_sb($sformatf("win_r%0d_c%0d", r, c));
  endtask

  task automatic sweep(input int r, input int from, input int to);
    for (int c = from; c <= to; c++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse(r, c);
    end
  endtask

  task automatic end_sweep();
    ram_update_flag = 1'b1;
    @(negedge clk);
    ram_update_flag = 1'b0;
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
  endtask

  initial begin
    #300000;
    n_bad++;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int st, st2, cal_cnt;
    tbl[0] = '{0,  16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1,  16'h0000, 16'h0000, 16'h0100, 1'b0};
    tbl[2] = '{2,  16'h0000, 16'h0001, 16'h0101, 1'b1};
    tbl[3] = '{5,  16'h0000, 16'h0004, 16'h0104, 1'b1};
    tbl[4] = '{25, 16'h0000, 16'h0018, 16'h0118, 1'b1};
    tbl[5] = '{26, 16'h0000, 16'h0000, 16'h0000, 1'b1};

    in_valid        = 1'b0;
    in_data         = '0;
    ram_update_flag = 1'b0;
    rst             = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_outputs", 64'(dut_win()), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_window_valid", 64'(window_valid), 64'(0));

    // Frame A: preload, continuous sweep 0, stall into WAIT.
    write_words(0, 0, W - 1, st);
    write_words(1, 0, W - 1, st2);
    chk("preload_stalls", 64'(st + st2), 64'(0));
    chk("preload_window_valid", 64'(window_valid), 64'(1));
    cal_cnt = 0;
    for (int c = 0; c <= W + 1; c++) begin
      if (c == 0) begin
        exp_q.push_back(model_win(0, 0));
        check_sb("win_r0_c0");
      end else begin
        pulse(0, c);
      end
      if (cal_flag) cal_cnt++;
      foreach (tbl[k])
        if (tbl[k].c == c)
          chk($sformatf("tbl_c%0d", c),
              64'({data_output_row0, data_output_row1, data_output_row2, cal_flag}),
              64'({tbl[k].e0, tbl[k].e1, tbl[k].e2, tbl[k].cal}));
    end
    end_sweep();
    if (cal_flag) cal_cnt++;
    chk("sweep0_cal_count", 64'(cal_cnt), 64'(W));
    chk("wait_window_valid", 64'(window_valid), 64'(0));
    ram_update_flag = 1'b1;
    repeat (2) @(negedge clk);
    ram_update_flag = 1'b0;
    @(negedge clk);
    chk("wait_hold_window_valid", 64'(window_valid), 64'(0));
    chk("wait_row_index", 64'(row_index), 64'(0));
    write_words(2, 0, W - 1, st);
    exp_q.push_back(model_win(1, 0));
    check_sb("stall_sweep1_start");
    sweep(1, 1, 10);

    // Reset in the middle of sweep 1.
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 64'(dut_win()), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    chk("midrst_frame_done", 64'(frame_done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rerst_in_ready", 64'(in_ready), 64'(1));
    chk("rerst_window_valid", 64'(window_valid), 64'(0));

    // Frame B: row 2 finishes on the final pulse of sweep 0, then the full frame.
    write_words(0, 0, W - 1, st);
    write_words(1, 0, W - 1, st2);
    exp_q.push_back(model_win(0, 0));
    check_sb("frameb_win_r0_c0");
    write_words(2, 0, W - 2, st);
    chk("frameb_row2_stalls", 64'(st), 64'(0));
    sweep(0, 1, W + 1);
    chk("same_edge_in_ready", 64'(in_ready), 64'(1));
    in_valid        = 1'b1;
    in_data         = DW'(2 * 256 + W - 1);
    ram_update_flag = 1'b1;
    @(negedge clk);
    in_valid        = 1'b0;
    ram_update_flag = 1'b0;
    exp_q.push_back(model_win(1, 0));
    check_sb("same_edge_rotate");
    write_words(3, 0, W - 1, st);
    chk("row3_stalls", 64'(st), 64'(0));
    chk("frame_full_in_ready", 64'(in_ready), 64'(0));
    for (int r = 1; r < R; r++) begin
      sweep(r, 1, W + 1);
      end_sweep();
      if (r < R - 1) begin
        exp_q.push_back(model_win(r + 1, 0));
        check_sb($sformatf("rotate_to_r%0d", r + 1));
      end else begin
        chk("done_frame_done", 64'(frame_done), 64'(1));
        chk("done_window_valid", 64'(window_valid), 64'(0));
      end
    end
    @(negedge clk);
    chk("after_done_frame_done", 64'(frame_done), 64'(0));
    chk("after_done_in_ready", 64'(in_ready), 64'(1));
    repeat (3) @(negedge clk);
    chk("frame_done_pulses", 64'(fd_cnt), 64'(1));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    summary();
    $finish;
  end

endmodule
